// File: rtl/alu_control_unit_if.sv
// Fetch bus between the ALU control unit (master) and instruction memory (slave).
interface alu_control_unit_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] pc;
    logic              instr_req;
    logic [7:0]        instr_data;
    logic              instr_valid;

    modport master (output pc, output instr_req, input instr_data, input instr_valid);
    modport slave  (input pc, input instr_req, output instr_data, output instr_valid);
endinterface

// File: rtl/alu_control_unit.sv
// Sequencer for the 8-bit accumulator ALU: fetches, decodes and executes 8-bit instructions,
// drives the ALU controls and owns the PC and carry/zero flags.
module alu_control_unit #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_control_unit_if.master fetch_bus,
    input  logic               cout,
    input  logic               zout,
    output logic [1:0]         ALU_sel,
    output logic [1:0]         load_shift,
    output logic [7:0]         imm,
    output logic               a_sel,
    output logic               acc_we,
    output logic               c_flag,
    output logic               z_flag,
    output logic               halted,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_RST   = 3'd0;
    localparam logic [2:0] OP_LD    = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_SHIFT = 3'd5;
    localparam logic [2:0] OP_JZ    = 3'd6;
    localparam logic [2:0] OP_JC    = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        instr;
    logic [CNT_W-1:0]  wait_cnt;
    logic              instr_req;

    logic              fetch_accept;
    logic              timeout_hit;
    logic              is_halt;
    logic              is_jump;
    logic              jump_taken;
    logic [2:0]        fetch_op;

    logic              instr_req_d;
    logic              acc_we_d;
    logic              halted_d;
    logic [1:0]        alu_sel_d;
    logic [1:0]        load_shift_d;
    logic [7:0]        imm_d;
    logic              a_sel_d;

    assign fetch_bus.pc        = pc;
    assign fetch_bus.instr_req = instr_req;

    assign fetch_accept = instr_req && fetch_bus.instr_valid;
    assign timeout_hit  = instr_req && !fetch_bus.instr_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign is_halt      = (instr == 8'hFF);
    assign is_jump      = (instr[7:5] == OP_JZ) || (instr[7:5] == OP_JC);
    assign jump_taken   = (instr[7:5] == OP_JZ) ? z_flag : c_flag;
    assign fetch_op     = fetch_bus.instr_data[7:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (fetch_accept) begin
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    next_state = S_HALT;
                end else if (is_jump) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE:   next_state = S_WRITEBACK;
            S_WRITEBACK: next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_FETCH;
        endcase
    end

    // Outputs are registered from the upcoming state so they stay at zero until the first edge after reset;
    // ALU controls change only when an ALU op is accepted, so jumps never disturb the ALU.
    always_comb begin
        instr_req_d  = (next_state == S_FETCH);
        acc_we_d     = (next_state == S_WRITEBACK);
        halted_d     = (next_state == S_HALT);
        alu_sel_d    = ALU_sel;
        load_shift_d = load_shift;
        imm_d        = imm;
        a_sel_d      = a_sel;
        if ((state == S_FETCH) && (next_state == S_DECODE) && (fetch_op != OP_JZ) && (fetch_op != OP_JC)) begin
            imm_d   = {3'b000, fetch_bus.instr_data[4:0]};
            a_sel_d = (fetch_op == OP_LD);
            case (fetch_op)
                OP_RST:   begin alu_sel_d = 2'b00; load_shift_d = 2'b00; end
                OP_LD:    begin alu_sel_d = 2'b00; load_shift_d = 2'b10; end
                OP_ADD:   alu_sel_d = 2'b10;
                OP_SUB:   alu_sel_d = 2'b11;
                OP_NOR:   alu_sel_d = 2'b01;
                OP_SHIFT: begin
                    alu_sel_d    = 2'b00;
                    load_shift_d = fetch_bus.instr_data[0] ? 2'b11 : 2'b01;
                end
                default:  alu_sel_d = ALU_sel;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= '0;
            wait_cnt   <= '0;
            c_flag     <= 1'b0;
            z_flag     <= 1'b0;
            fetch_err  <= 1'b0;
            instr_req  <= 1'b0;
            acc_we     <= 1'b0;
            halted     <= 1'b0;
            ALU_sel    <= 2'b00;
            load_shift <= 2'b00;
            imm        <= 8'h00;
            a_sel      <= 1'b0;
        end else begin
            instr_req  <= instr_req_d;
            acc_we     <= acc_we_d;
            halted     <= halted_d;
            ALU_sel    <= alu_sel_d;
            load_shift <= load_shift_d;
            imm        <= imm_d;
            a_sel      <= a_sel_d;
            case (state)
                S_FETCH: begin
                    if (fetch_accept) begin
                        instr    <= fetch_bus.instr_data;
                        wait_cnt <= '0;
                    end else if (instr_req) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (timeout_hit) begin
                            fetch_err <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (is_jump && !is_halt) begin
                        pc <= jump_taken ? ADDR_W'(instr[4:0]) : pc + ADDR_W'(1);
                    end
                end
                S_WRITEBACK: begin
                    c_flag <= cout;
                    z_flag <= zout;
                    pc     <= pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed and randomised checks of alu_control_unit against an instruction-level model of the ISA.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cout = 1'b0;
    logic       zout = 1'b0;
    logic [1:0] ALU_sel;
    logic [1:0] load_shift;
    logic [7:0] imm;
    logic       a_sel;
    logic       acc_we;
    logic       c_flag;
    logic       z_flag;
    logic       halted;
    logic       fetch_err;

    int checks = 0;
    int errors = 0;

    // Architectural model: program counter and flags as seen between instructions.
    int m_pc = 0;
    bit m_c  = 1'b0;
    bit m_z  = 1'b0;

    alu_control_unit_if #(.ADDR_W(5)) bus ();

    alu_control_unit #(
        .ADDR_W   (5),
        .RESET_PC (5'd0),
        .TIMEOUT  (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_bus  (bus),
        .cout       (cout),
        .zout       (zout),
        .ALU_sel    (ALU_sel),
        .load_shift (load_shift),
        .imm        (imm),
        .a_sel      (a_sel),
        .acc_we     (acc_we),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] model_alu_sel(input logic [7:0] ins);
        case (ins[7:5])
            3'd2:    return 2'b10;
            3'd3:    return 2'b11;
            3'd4:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] model_load_shift(input logic [7:0] ins);
        case (ins[7:5])
            3'd1:    return 2'b10;
            3'd5:    return ins[0] ? 2'b11 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_controls(input string phase, input logic [7:0] ins);
        check_output({phase, "_alu_sel"}, 32'(ALU_sel), 32'(model_alu_sel(ins)));
        if (model_alu_sel(ins) == 2'b00) begin
            check_output({phase, "_load_shift"}, 32'(load_shift), 32'(model_load_shift(ins)));
        end
        check_output({phase, "_a_sel"}, 32'(a_sel), (ins[7:5] == 3'd1) ? 32'd1 : 32'd0);
        check_output({phase, "_imm"}, 32'(imm), 32'(ins[4:0]));
    endtask

    task automatic check_flags(input string phase);
        check_output({phase, "_c_flag"}, 32'(c_flag), 32'(m_c));
        check_output({phase, "_z_flag"}, 32'(z_flag), 32'(m_z));
    endtask

    // Runs one instruction starting from a falling edge in FETCH; returns on a falling edge after it completes.
    task automatic apply_stimulus(input logic [7:0] ins, input bit c_in, input bit z_in,
                                  input int delay, input bit linger);
        int op;
        int arg;
        int nxt;
        bit taken;
        op  = int'(ins[7:5]);
        arg = int'(ins[4:0]);
        nxt = (m_pc + 1) % 32;
        bus.instr_valid = 1'b0;
        check_output("fetch_req", 32'(bus.instr_req), 32'd1);
        check_output("fetch_pc", 32'(bus.pc), 32'(m_pc));
        repeat (delay) @(negedge clk);
        check_output("fetch_pc_held", 32'(bus.pc), 32'(m_pc));
        bus.instr_data  = ins;
        bus.instr_valid = 1'b1;
        cout = c_in;
        zout = z_in;
        @(negedge clk);
        if (linger) begin
            bus.instr_data = 8'($urandom);
        end else begin
            bus.instr_valid = 1'b0;
        end
        check_output("decode_acc_we", 32'(acc_we), 32'd0);
        check_output("decode_req", 32'(bus.instr_req), 32'd0);
        if (ins == 8'hFF) begin
            bus.instr_valid = 1'b0;
            @(negedge clk);
            check_output("halt_halted", 32'(halted), 32'd1);
            check_output("halt_req", 32'(bus.instr_req), 32'd0);
            check_output("halt_pc", 32'(bus.pc), 32'(m_pc));
            check_output("halt_fetch_err", 32'(fetch_err), 32'd0);
            check_flags("halt");
        end else if (op >= 6) begin
            bus.instr_valid = 1'b0;
            taken = (op == 6) ? m_z : m_c;
            m_pc  = taken ? arg : nxt;
            @(negedge clk);
            check_output("jump_acc_we", 32'(acc_we), 32'd0);
            check_output("jump_pc", 32'(bus.pc), 32'(m_pc));
            check_flags("jump");
        end else begin
            check_controls("decode", ins);
            @(negedge clk);
            check_output("execute_acc_we", 32'(acc_we), 32'd0);
            check_controls("execute", ins);
            @(negedge clk);
            bus.instr_valid = 1'b0;
            check_output("wb_acc_we", 32'(acc_we), 32'd1);
            check_controls("wb", ins);
            check_flags("wb_old");
            m_c  = c_in;
            m_z  = z_in;
            m_pc = nxt;
            @(negedge clk);
            check_output("post_acc_we", 32'(acc_we), 32'd0);
            check_output("post_pc", 32'(bus.pc), 32'(m_pc));
            check_flags("post");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        cout = 1'b0;
        zout = 1'b0;
        #1;
        check_output("rst_pc", 32'(bus.pc), 32'd0);
        check_output("rst_req", 32'(bus.instr_req), 32'd0);
        check_output("rst_alu_sel", 32'(ALU_sel), 32'd0);
        check_output("rst_load_shift", 32'(load_shift), 32'd0);
        check_output("rst_imm", 32'(imm), 32'd0);
        check_output("rst_a_sel", 32'(a_sel), 32'd0);
        check_output("rst_acc_we", 32'(acc_we), 32'd0);
        check_output("rst_c_flag", 32'(c_flag), 32'd0);
        check_output("rst_z_flag", 32'(z_flag), 32'd0);
        check_output("rst_halted", 32'(halted), 32'd0);
        check_output("rst_fetch_err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 0;
        m_c  = 1'b0;
        m_z  = 1'b0;
        #1;
        check_output("release_req_low", 32'(bus.instr_req), 32'd0);
        @(negedge clk);
        check_output("release_req_high", 32'(bus.instr_req), 32'd1);
    endtask

    initial begin
        int req_cycles;
        logic [7:0] ins;
        bus.instr_data  = 8'h00;
        bus.instr_valid = 1'b0;
        $display("[TB] start");

        do_reset();
        apply_stimulus(8'h25, 1'b0, 1'b0, 0, 1'b0);
        apply_stimulus(8'h65, 1'b0, 1'b1, 0, 1'b0);
        apply_stimulus(8'hCA, 1'b1, 1'b0, 0, 1'b0);
        check_output("jz_target", 32'(bus.pc), 32'd10);
        apply_stimulus(8'hDF, 1'b0, 1'b0, 1, 1'b0);
        apply_stimulus(8'hE3, 1'b1, 1'b1, 0, 1'b0);
        check_output("jc_wrap", 32'(bus.pc), 32'd0);
        apply_stimulus(8'hA1, 1'b1, 1'b0, 2, 1'b1);
        apply_stimulus(8'hA0, 1'b0, 1'b0, 14, 1'b0);

        for (int i = 0; i < 80; i++) begin
            ins = 8'($urandom_range(0, 254));
            apply_stimulus(ins, 1'($urandom), 1'($urandom), $urandom_range(0, 14), 1'($urandom));
        end

        apply_stimulus(8'hFF, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr_data  = 8'h25;
            @(negedge clk);
            check_output("halt_stay", 32'(halted), 32'd1);
            check_output("halt_stay_pc", 32'(bus.pc), 32'(m_pc));
            check_output("halt_stay_acc_we", 32'(acc_we), 32'd0);
        end
        bus.instr_valid = 1'b0;

        // Reset while an ADD is in EXECUTE must drop its write strobe.
        do_reset();
        apply_stimulus(8'h41, 1'b1, 1'b1, 0, 1'b0);
        bus.instr_data  = 8'h47;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check_output("abort_decode_alu_sel", 32'(ALU_sel), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort_acc_we", 32'(acc_we), 32'd0);
        check_output("abort_pc", 32'(bus.pc), 32'd0);
        check_output("abort_alu_sel", 32'(ALU_sel), 32'd0);
        check_output("abort_imm", 32'(imm), 32'd0);
        check_output("abort_c_flag", 32'(c_flag), 32'd0);
        check_output("abort_z_flag", 32'(z_flag), 32'd0);
        @(negedge clk);
        check_output("abort_no_we", 32'(acc_we), 32'd0);
        rst_n = 1'b1;
        m_pc = 0;
        m_c  = 1'b0;
        m_z  = 1'b0;
        @(negedge clk);
        check_output("abort_restart_req", 32'(bus.instr_req), 32'd1);
        apply_stimulus(8'hFF, 1'b0, 1'b0, 3, 1'b0);

        // Fetch timeout: no instr_valid ever arrives.
        do_reset();
        req_cycles = 0;
        for (int i = 0; i < 40 && bus.instr_req; i++) begin
            req_cycles++;
            @(negedge clk);
        end
        check_output("timeout_req_cycles", 32'(req_cycles), 32'd15);
        check_output("timeout_halted", 32'(halted), 32'd1);
        check_output("timeout_fetch_err", 32'(fetch_err), 32'd1);
        check_output("timeout_req", 32'(bus.instr_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr_data  = 8'h25;
            @(negedge clk);
            check_output("timeout_stay_halted", 32'(halted), 32'd1);
            check_output("timeout_stay_req", 32'(bus.instr_req), 32'd0);
            check_output("timeout_stay_err", 32'(fetch_err), 32'd1);
        end
        bus.instr_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
